// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM port controller and its statistics block.
package sram_pkg;

    localparam int unsigned SRAM_ADDR_W = 8;
    localparam int unsigned SRAM_DATA_W = 8;
    localparam int unsigned SRAM_DEPTH  = 256;
    localparam int unsigned STATE_W     = 3;
    localparam int unsigned STAT_W      = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_RSP     = 3'd4
    } state_e;

    // Chip select is active in every state that puts a cycle on the SRAM pins.
    function automatic logic state_selects_ram(input state_e s);
        return (s == ST_WR) || (s == ST_RD_ADDR) || (s == ST_RD_DATA);
    endfunction

endpackage

// File: rtl/sram_port_stats.sv
// Saturating write/read transaction counters with a synchronous clear.
module sram_port_stats
    import sram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              wr_inc_i,
    input  logic              rd_inc_i,
    output logic [STAT_W-1:0] wr_cnt_o,
    output logic [STAT_W-1:0] rd_cnt_o
);

    localparam logic [STAT_W-1:0] CNT_MAX = '1;

    logic [STAT_W-1:0] wr_q, wr_d;
    logic [STAT_W-1:0] rd_q, rd_d;

    // Next counter values: clear has priority over a same-cycle increment.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clr_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (wr_inc_i && (wr_q != CNT_MAX)) begin
                wr_d = wr_q + STAT_W'(1);
            end
            if (rd_inc_i && (rd_q != CNT_MAX)) begin
                rd_d = rd_q + STAT_W'(1);
            end
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    assign wr_cnt_o = wr_q;
    assign rd_cnt_o = rd_q;

endmodule

// File: rtl/sram_port_ctrl.sv
// Request/response front end for a single-port SRAM macro: sequences
// cs/we/oe/addr and owns the fabric-side tristate driver on the data bus.
// Optional SRAM_PORT_CTRL_STATS_EN adds stat_clr/stat_wr_cnt/stat_rd_cnt.
module sram_port_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SRAM_ADDR_W,
    parameter int unsigned DATA_WIDTH = SRAM_DATA_W,
    parameter int unsigned DEPTH      = SRAM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
`ifdef SRAM_PORT_CTRL_STATS_EN
    input  logic                  stat_clr,
    output logic [STAT_W-1:0]     stat_wr_cnt,
    output logic [STAT_W-1:0]     stat_rd_cnt,
`endif
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    // Out-of-range addresses are passed through untouched; only the
    // parameter set itself is sanity-checked at elaboration.
    if ((DEPTH == 0) || (DEPTH > (32'd1 << ADDR_WIDTH))) begin : g_bad_depth
        $error("sram_port_ctrl: DEPTH does not fit ADDR_WIDTH");
    end

    state_e                state_q, state_d;
    logic                  req_ready_q;
    logic                  ram_cs_q, ram_we_q, ram_oe_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  accept;

    // Next-state decode; requests only land in IDLE, responses only leave RSP.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    accept  = 1'b1;
                    state_d = req_we ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_WR:      state_d = ST_IDLE;
            ST_RD_ADDR: state_d = ST_RD_DATA;
            ST_RD_DATA: state_d = ST_RSP;
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // State plus all pin/handshake registers, decoded from the next state so
    // the SRAM sees clean registered controls aligned with each FSM state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            ram_addr_q  <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == ST_IDLE);
            ram_cs_q    <= state_selects_ram(state_d);
            ram_we_q    <= (state_d == ST_WR);
            ram_oe_q    <= (state_d == ST_RD_DATA);
            rsp_valid_q <= (state_d == ST_RSP);
            if (accept) begin
                ram_addr_q <= req_addr;
                wdata_q    <= req_wdata;
            end
            if (state_q == ST_RD_DATA) begin
                rsp_rdata_q <= ram_data;
            end
        end
    end

    // Only tristate driver on the bus: enabled solely by the registered write strobe.
    assign ram_data = ram_we_q ? wdata_q : {DATA_WIDTH{1'bz}};

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ram_cs    = ram_cs_q;
    assign ram_we    = ram_we_q;
    assign ram_oe    = ram_oe_q;
    assign ram_addr  = ram_addr_q;

`ifdef SRAM_PORT_CTRL_STATS_EN
    // Writes count when WR retires, reads when the response is handed over.
    sram_port_stats u_stats (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (stat_clr),
        .wr_inc_i (state_q == ST_WR),
        .rd_inc_i ((state_q == ST_RSP) && rsp_ready),
        .wr_cnt_o (stat_wr_cnt),
        .rd_cnt_o (stat_rd_cnt)
    );
`endif

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl with a behavioural single-port SRAM on the shared bus.
module tb_sram_port_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       ram_cs, ram_we, ram_oe;
    logic [7:0] ram_addr;
    wire  [7:0] ram_data;
`ifdef SRAM_PORT_CTRL_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_wr_cnt, stat_rd_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
`ifdef SRAM_PORT_CTRL_STATS_EN
        .stat_clr    (stat_clr),
        .stat_wr_cnt (stat_wr_cnt),
        .stat_rd_cnt (stat_rd_cnt),
`endif
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data)
    );

    // SRAM model: writes and read-latches on the edge, drives the bus while oe.
    logic [7:0] mem [256];
    logic [7:0] rd_latch;
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
        if (ram_cs && !ram_we) rd_latch <= mem[ram_addr];
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? rd_latch : 8'bz;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock, sampled 1ns after the edge, with the bus-ownership invariant.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("we_oe_exclusive", 16'(ram_we & ram_oe), 16'h0);
    endtask

    task automatic chk_pins(input string name, input logic cs, input logic we, input logic oe);
        chk({name, "_cs"}, 16'(ram_cs), 16'(cs));
        chk({name, "_we"}, 16'(ram_we), 16'(we));
        chk({name, "_oe"}, 16'(ram_oe), 16'(oe));
    endtask

    // Full transaction from IDLE with cycle-by-cycle pin and handshake checks.
    task automatic do_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp_rdata);
        chk("idle_ready", 16'(req_ready), 16'h1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        chk("acc_addr", 16'(ram_addr), 16'(addr));
        chk("acc_ready", 16'(req_ready), 16'h0);
        if (we) begin
            chk_pins("wr", 1'b1, 1'b1, 1'b0);
            tick();
            chk_pins("wr_done", 1'b0, 1'b0, 1'b0);
            chk("wr_done_ready", 16'(req_ready), 16'h1);
        end else begin
            chk_pins("rd_addr", 1'b1, 1'b0, 1'b0);
            chk("rd_addr_vld", 16'(rsp_valid), 16'h0);
            tick();
            chk_pins("rd_data", 1'b1, 1'b0, 1'b1);
            chk("rd_data_vld", 16'(rsp_valid), 16'h0);
            chk("rd_data_ready", 16'(req_ready), 16'h0);
            tick();
            chk_pins("rsp", 1'b0, 1'b0, 1'b0);
            chk("rsp_valid", 16'(rsp_valid), 16'h1);
            chk("rsp_rdata", 16'(rsp_rdata), 16'(exp_rdata));
            chk("rsp_ready_out", 16'(req_ready), 16'h0);
            tick();
            chk("rsp_done_vld", 16'(rsp_valid), 16'h0);
            chk("rsp_done_ready", 16'(req_ready), 16'h1);
        end
    endtask

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 8'h10, 8'hA5, 8'h00};
        vecs[1]  = '{1'b0, 8'h10, 8'h00, 8'hA5};
        vecs[2]  = '{1'b1, 8'hFC, 8'h01, 8'h00};
        vecs[3]  = '{1'b1, 8'hFD, 8'h02, 8'h00};
        vecs[4]  = '{1'b1, 8'hFE, 8'h03, 8'h00};
        vecs[5]  = '{1'b1, 8'hFF, 8'h04, 8'h00};
        vecs[6]  = '{1'b0, 8'hFC, 8'h00, 8'h01};
        vecs[7]  = '{1'b0, 8'hFD, 8'h00, 8'h02};
        vecs[8]  = '{1'b0, 8'hFE, 8'h00, 8'h03};
        vecs[9]  = '{1'b0, 8'hFF, 8'h00, 8'h04};
        vecs[10] = '{1'b1, 8'h00, 8'h5A, 8'h00};
        vecs[11] = '{1'b0, 8'h00, 8'h00, 8'h5A};

        rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h55; req_wdata = 8'hEE;
        rsp_ready = 1'b1;
`ifdef SRAM_PORT_CTRL_STATS_EN
        stat_clr = 1'b0;
`endif

        // Reset held with a pending request: nothing accepted, pins quiet.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", 16'(req_ready), 16'h0);
            chk_pins("rst", 1'b0, 1'b0, 1'b0);
            chk("rst_addr", 16'(ram_addr), 16'h0);
            chk("rst_vld", 16'(rsp_valid), 16'h0);
            chk("rst_rdata", 16'(rsp_rdata), 16'h0);
        end
        rst_n = 1'b1; req_valid = 1'b0;
        tick();
        chk("post_rst_ready", 16'(req_ready), 16'h1);

        for (int i = 0; i < NVEC; i++) begin
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
        end

        // Stalled response: held stable, new requests ignored.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
        tick();
        req_we = 1'b1; req_addr = 8'h33; req_wdata = 8'hCC;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_vld", 16'(rsp_valid), 16'h1);
            chk("stall_rdata", 16'(rsp_rdata), 16'h00A5);
            chk("stall_ready", 16'(req_ready), 16'h0);
            chk("stall_we", 16'(ram_we), 16'h0);
            tick();
        end
        chk("stall_end_vld", 16'(rsp_valid), 16'h1);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("stall_rel_vld", 16'(rsp_valid), 16'h0);
        chk("stall_rel_ready", 16'(req_ready), 16'h1);
        do_txn(1'b0, 8'h33, 8'h00, mem[8'h33]);

        // Reset in RD_DATA drops the read; a retry returns correct data.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rd_data_before_rst", 16'(ram_oe), 16'h1);
        rst_n = 1'b0;
        tick();
        chk_pins("rst_rd", 1'b0, 1'b0, 1'b0);
        chk("rst_rd_vld", 16'(rsp_valid), 16'h0);
        chk("rst_rd_addr", 16'(ram_addr), 16'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_rd_vld2", 16'(rsp_valid), 16'h0);
        do_txn(1'b0, 8'h10, 8'h00, 8'hA5);

        // Reset during WR: the write on the pins still lands.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 8'h77;
        tick();
        req_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("rst_wr_we", 16'(ram_we), 16'h0);
        rst_n = 1'b1;
        tick();
        do_txn(1'b0, 8'h20, 8'h00, 8'h77);

`ifdef SRAM_PORT_CTRL_STATS_EN
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("stat_clr_wr", stat_wr_cnt, 16'd0);
        chk("stat_clr_rd", stat_rd_cnt, 16'd0);
        do_txn(1'b1, 8'h40, 8'h11, 8'h00);
        do_txn(1'b1, 8'h41, 8'h22, 8'h00);
        do_txn(1'b1, 8'h42, 8'h33, 8'h00);
        do_txn(1'b0, 8'h40, 8'h00, 8'h11);
        do_txn(1'b0, 8'h42, 8'h00, 8'h33);
        chk("stat_wr3", stat_wr_cnt, 16'd3);
        chk("stat_rd2", stat_rd_cnt, 16'd2);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h43; req_wdata = 8'h44;
        tick();
        req_valid = 1'b0;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("stat_clr_wins_wr", stat_wr_cnt, 16'd0);
        chk("stat_clr_wins_rd", stat_rd_cnt, 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
